// File: rtl/esc_passthrough_scheduler.sv
// Hands the per-motor ESC pads between the DSHOT engine and the UART passthrough bridge,
// with a drain step, an idle-high guard on each side, and a bridge-inactivity auto-exit.
module esc_passthrough_scheduler #(
    parameter int unsigned NUM_MOTORS          = 4,
    parameter int unsigned GUARD_CYCLES        = 72_000,
    parameter int unsigned IDLE_TIMEOUT_CYCLES = 360_000_000,
    localparam int unsigned MW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_passthrough,
    input  logic [MW-1:0] req_motor,
    input  logic          dshot_busy,
    input  logic          bridge_active,
    output logic          dshot_enable,
    output logic          bridge_enable,
    output logic          pad_force_high,
    output logic [MW-1:0] motor_sel,
    output logic [2:0]    state_o,
    output logic          timeout_evt,
    output logic          req_err
);

    typedef enum logic [2:0] {
        ST_DSHOT     = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_GUARD_IN  = 3'd2,
        ST_PASSTHRU  = 3'd3,
        ST_GUARD_OUT = 3'd4
    } state_e;

    localparam logic [MW:0]  NUM_M      = (MW+1)'(NUM_MOTORS);
    localparam logic [31:0]  GUARD_LAST = 32'(GUARD_CYCLES - 1);
    localparam logic [31:0]  IDLE_LAST  = 32'(IDLE_TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [MW-1:0] motor_q, motor_d;
    logic [31:0]   guard_q, guard_d;
    logic [31:0]   idle_q, idle_d;
    logic          block_q, block_d;
    logic          req_prev_q;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;
    logic          motor_valid;

    assign motor_valid = ({1'b0, req_motor} < NUM_M);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DSHOT;
            motor_q    <= '0;
            guard_q    <= '0;
            idle_q     <= '0;
            block_q    <= 1'b0;
            req_prev_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            motor_q    <= motor_d;
            guard_q    <= guard_d;
            idle_q     <= idle_d;
            block_q    <= block_d;
            req_prev_q <= req_passthrough;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    // Both counters fall back to zero unless the current state is actively counting,
    // so every guard/passthrough entry starts from a cleared count.
    always_comb begin
        state_d   = state_q;
        motor_d   = motor_q;
        guard_d   = '0;
        idle_d    = '0;
        block_d   = req_passthrough ? block_q : 1'b0;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_DSHOT: begin
                if (req_passthrough) begin
                    if (!motor_valid) begin
                        err_d = !req_prev_q;
                    end else if (!block_q) begin
                        motor_d = req_motor;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!req_passthrough)  state_d = ST_DSHOT;
                else if (!dshot_busy)  state_d = ST_GUARD_IN;
            end
            ST_GUARD_IN: begin
                if (!req_passthrough)           state_d = ST_GUARD_OUT;
                else if (guard_q == GUARD_LAST) state_d = ST_PASSTHRU;
                else                            guard_d = guard_q + 32'd1;
            end
            ST_PASSTHRU: begin
                // A software release takes priority over a coincident timeout.
                if (!req_passthrough) begin
                    state_d = ST_GUARD_OUT;
                end else if (!bridge_active) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d   = ST_GUARD_OUT;
                        timeout_d = 1'b1;
                        block_d   = 1'b1;
                    end else begin
                        idle_d = idle_q + 32'd1;
                    end
                end
            end
            ST_GUARD_OUT: begin
                if (guard_q == GUARD_LAST) state_d = ST_DSHOT;
                else                       guard_d = guard_q + 32'd1;
            end
            default: state_d = ST_DSHOT;
        endcase
    end

    assign dshot_enable   = (state_q == ST_DSHOT);
    assign bridge_enable  = (state_q == ST_PASSTHRU);
    assign pad_force_high = (state_q == ST_GUARD_IN) || (state_q == ST_GUARD_OUT);
    assign motor_sel      = motor_q;
    assign state_o        = state_q;
    assign timeout_evt    = timeout_q;
    assign req_err        = err_q;

endmodule
